uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter and sequencer that shares one UART transmitter among `N_REQ` byte-producing clients. It sits between the client logic and the UART TX core. It selects one pending client, latches its byte, pulses the transmitter's start, and holds ownership until the transmitter reports frame completion. It then rotates priority so no client starves.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 2..16.
- `TIMEOUT_CYC`, default 20000: watchdog limit in clock cycles. Used only with `UART_ARB_TIMEOUT_EN`.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  N_REQ  per-client request; held high with stable data until `gnt`.
- `req_data`  in  N_REQ*8  client i byte in bits [8i+7:8i].
- `gnt`  out  N_REQ  one-hot, one-cycle pulse; the client's byte has been taken.
- `tx_data`  out  8  byte to the UART TX; stable from `tx_start` until `tx_done`.
- `tx_start`  out  1  one-cycle pulse that launches a frame.
- `tx_busy`  in  1  transmitter busy; no start is issued while it is high.
- `tx_done`  in  1  one-cycle pulse at end of stop bit.
- `owner`  out  $clog2(N_REQ)  index of the client currently served.
- `active`  out  1  a frame is in flight under arbiter control.
- `err`  out  1  one-cycle pulse on watchdog expiry. Tied 0 without the macro.

## Operation
- States:
  - IDLE: waits for a request.
  - WAIT_DONE: a frame is in flight.
- IDLE → WAIT_DONE when `|req` is high and `tx_busy` is low.
  - Winner is the first requesting index searched from `last+1` upward, wrapping modulo N_REQ.
  - On the transition, register `tx_data <= req_data[winner]`, `owner <= winner`, `gnt[winner] <= 1`, `tx_start <= 1`, `active <= 1`.
- WAIT_DONE → IDLE on `tx_done`.
  - `last <= owner`, `active <= 0`.
- `gnt` and `tx_start` are high for exactly one cycle, the first cycle of WAIT_DONE.
- After `gnt`, the client may drop `req` or present its next byte. The arbiter ignores `req` until it returns to IDLE.
- `req` deasserted before grant: the client is skipped and no byte is sent.
- `tx_done` in IDLE is ignored.
- `tx_busy` high in IDLE stalls the grant; the request stays pending.
- `last` reset value is N_REQ-1, so client 0 has top priority after reset.
- Reset values: `gnt`=0, `tx_start`=0, `tx_data`=0, `owner`=0, `active`=0, `err`=0, state IDLE.
- Reset mid-frame: return to IDLE immediately; the partially sent frame is abandoned and no `gnt` is re-issued.

## Timing
- Arbitration latency: `req` sampled high in IDLE at cycle t gives `tx_start` and `gnt` at cycle t+1.
- Turnaround: `tx_done` at cycle d puts the arbiter in IDLE at d+1, so the next `tx_start` is at d+2 at the earliest.
- `owner` and `tx_data` hold from t+1 through the `tx_done` cycle.
- Fairness: under continuous requests from all clients, grants cycle 0,1,…,N_REQ-1,0 with no client served twice in a row.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT_DONE and increments each cycle there.
  - When the count reaches `TIMEOUT_CYC` without `tx_done`: `err` pulses for one cycle, the state returns to IDLE, and `last <= owner` (rotation advances).
- `UART_ARB_TIMEOUT_EN` undefined: no counter, `err` is constant 0, and WAIT_DONE waits indefinitely.

## Structure
- Package `uart_pkg` holds the arbiter state enum (`ARB_IDLE`, `ARB_WAIT_DONE`) and the shared UART byte width constant (8).
- Sub-module `rr_pick`: a combinational round-robin selector.
  - Inputs: `req` and `last`.
  - Outputs: `winner` index and `valid`.
  - Built from a doubled request vector with a priority encode.

## Test plan
- Reset, then `req`=4'b0001, `req_data[7:0]`=8'hA5 → at the next cycle `tx_start`=1, `gnt`=4'b0001, `tx_data`=8'hA5, `owner`=0; `active` stays 1 until `tx_done`.
- `req`=4'b1111 held; model TX returns `tx_done` 10 cycles after each start → grant order 0,1,2,3,0; each start lands 2 cycles after the previous `tx_done`.
- `tx_busy`=1 with `req`=4'b0100 → no `tx_start` or `gnt`; drop `tx_busy` → `gnt`=4'b0100 on the next cycle.
- `rst` pulsed 3 cycles after a start with `req`=4'b0010 → outputs return to reset values; after release, client 1 is re-granted with a fresh `tx_start`.
- Spurious `tx_done` in IDLE with `req`=0 → no state change and no output activity.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=50, `tx_done` never asserted → `err` pulses 50 cycles after `tx_start`, `active` falls, and the next pending client is granted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int UART_W = 8;

    typedef enum logic [0:0] {
        ARB_IDLE      = 1'b0,
        ARB_WAIT_DONE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: first set request strictly after `last`, wrapping.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     valid
);

    localparam int LW = $clog2(N_REQ);

    logic [2*N_REQ-1:0] dbl_shifted;
    logic [N_REQ-1:0]   rot;
    int unsigned        off;

    // Rotating the doubled vector puts index last+1 at bit 0, so the lowest set bit wins.
    always_comb begin
        dbl_shifted = {req, req} >> (32'(last) + 32'd1);
        rot         = dbl_shifted[N_REQ-1:0];
        off         = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        valid  = |req;
        winner = LW'((32'(last) + 32'd1 + off) % N_REQ);
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX among N_REQ clients.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort frames lacking tx_done.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*8-1:0]       req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [UART_W-1:0]        tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     active,
    output logic                     err
);

    localparam int LW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
        $error("uart_tx_arb: N_REQ or TIMEOUT_CYC out of range");
    end

    arb_state_t      state;
    logic [LW-1:0]   last;
    logic [LW-1:0]   pick_winner;
    logic            pick_valid;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .last   (last),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            last     <= LW'(N_REQ - 1);
            gnt      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            owner    <= '0;
            active   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err      <= 1'b0;
            wd_cnt   <= '0;
`endif
        end else begin
            gnt      <= '0;
            tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err      <= 1'b0;
`endif
            case (state)
                ARB_IDLE: begin
                    if (pick_valid && !tx_busy) begin
                        state    <= ARB_WAIT_DONE;
                        owner    <= pick_winner;
                        tx_data  <= req_data[int'(pick_winner)*UART_W +: UART_W];
                        gnt      <= N_REQ'(1) << pick_winner;
                        tx_start <= 1'b1;
                        active   <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                    end
                end
                ARB_WAIT_DONE: begin
                    if (tx_done) begin
                        state  <= ARB_IDLE;
                        last   <= owner;
                        active <= 1'b0;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    // Abandoned frame still advances rotation so a stuck client cannot hog the TX.
                    else if (wd_cnt == 16'(TIMEOUT_CYC - 1)) begin
                        state  <= ARB_IDLE;
                        last   <= owner;
                        active <= 1'b0;
                        err    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: per-cycle reference model plus directed literal checks.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int TO = 50;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [1:0]     owner;
    logic           active;
    logic           err;

    uart_tx_arb #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .owner    (owner),
        .active   (active),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: who is served, with which byte, and for how long.
    int         m_last = N - 1;
    bit         m_inflight = 0;
    int         m_owner = 0;
    logic [7:0] m_data = 0;
    logic [N-1:0] m_gnt = 0;
    bit         m_start = 0;
    bit         m_err = 0;
    int         m_age = 0;
    int         m_idx;

    always @(posedge clk) begin
        m_gnt   = '0;
        m_start = 0;
        m_err   = 0;
        if (rst) begin
            m_last = N - 1; m_inflight = 0; m_owner = 0; m_data = 0; m_age = 0;
        end else if (!m_inflight) begin
            if (req != 0 && !tx_busy) begin
                for (int k = 1; k <= N; k++) begin
                    m_idx = (m_last + k) % N;
                    if (req[m_idx]) begin
                        m_owner = m_idx;
                        break;
                    end
                end
                m_data = req_data[m_owner*8 +: 8];
                m_gnt[m_owner] = 1'b1;
                m_start = 1;
                m_inflight = 1;
                m_age = 0;
            end
        end else begin
            m_age++;
            if (tx_done) begin
                m_last = m_owner; m_inflight = 0;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (m_age == TO) begin
                m_last = m_owner; m_inflight = 0; m_err = 1;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt",      32'(gnt),      32'(m_gnt));
            check("tx_start", 32'(tx_start), 32'(m_start));
            check("tx_data",  32'(tx_data),  32'(m_data));
            check("owner",    32'(owner),    32'(m_owner));
            check("active",   32'(active),   32'(m_inflight));
            check("err",      32'(err),      32'(m_err));
        end
    end

    // Transmitter stand-in: tx_done ten cycles after each start, plus event logs.
    bit auto_tx = 0;
    int tx_cnt = 0;
    int grant_q[$];
    int start_q[$];
    int done_q[$];

    always @(negedge clk) begin
        if (tx_start === 1'b1) start_q.push_back(cyc);
        for (int i = 0; i < N; i++) if (gnt[i] === 1'b1) grant_q.push_back(i);
        if (auto_tx) begin
            if (tx_done) tx_done = 1'b0;
            if (tx_start === 1'b1) tx_cnt = 10;
            else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_done = 1'b1;
                    done_q.push_back(cyc);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    int t0;
    int n;

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        rst = 1'b0;

        // Single request from client 0
        req = 4'b0001;
        req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
        @(negedge clk);
        check("t1_start", 32'(tx_start), 32'd1);
        check("t1_gnt",   32'(gnt),      32'h1);
        check("t1_data",  32'(tx_data),  32'hA5);
        check("t1_owner", 32'(owner),    32'd0);
        req = '0;
        repeat (5) @(negedge clk);
        check("t1_active_held", 32'(active), 32'd1);
        check("t1_data_held",   32'(tx_data), 32'hA5);
        pulse_done();
        check("t1_active_drop", 32'(active), 32'd0);

        // Continuous requests from everyone
        do_reset();
        grant_q.delete(); start_q.delete(); done_q.delete();
        req = 4'b1111;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        auto_tx = 1;
        n = 0;
        while (grant_q.size() < 5 && n < 200) begin @(negedge clk); n++; end
        req = '0;
        check("t2_grant_count", 32'(grant_q.size() >= 5), 32'd1);
        if (grant_q.size() >= 5) begin
            check("t2_order0", 32'(grant_q[0]), 32'd0);
            check("t2_order1", 32'(grant_q[1]), 32'd1);
            check("t2_order2", 32'(grant_q[2]), 32'd2);
            check("t2_order3", 32'(grant_q[3]), 32'd3);
            check("t2_order4", 32'(grant_q[4]), 32'd0);
        end
        if (start_q.size() >= 5 && done_q.size() >= 4) begin
            for (int i = 1; i < 5; i++) check("t2_turnaround", 32'(start_q[i] - done_q[i-1]), 32'd2);
        end else begin
            check("t2_log_sizes", 32'(start_q.size()), 32'd5);
        end
        n = 0;
        while (active !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        check("t2_drain", 32'(active), 32'd0);
        auto_tx = 0;
        tx_done = 1'b0;

        // Busy transmitter stalls the grant
        do_reset();
        tx_busy = 1'b1;
        req = 4'b0100;
        repeat (5) begin
            @(negedge clk);
            check("t3_busy_start", 32'(tx_start), 32'd0);
            check("t3_busy_gnt",   32'(gnt),      32'd0);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        check("t3_gnt",   32'(gnt),      32'h4);
        check("t3_start", 32'(tx_start), 32'd1);
        req = '0;
        pulse_done();

        // Reset in the middle of a frame
        do_reset();
        req = 4'b0010;
        req_data = {8'h00, 8'h00, 8'h5C, 8'h00};
        @(negedge clk);
        check("t4_first_start", 32'(tx_start), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_gnt",    32'(gnt),      32'd0);
        check("t4_rst_start",  32'(tx_start), 32'd0);
        check("t4_rst_active", 32'(active),   32'd0);
        check("t4_rst_owner",  32'(owner),    32'd0);
        check("t4_rst_data",   32'(tx_data),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t4_regrant_start", 32'(tx_start), 32'd1);
        check("t4_regrant_gnt",   32'(gnt),      32'h2);
        check("t4_regrant_data",  32'(tx_data),  32'h5C);
        req = '0;
        pulse_done();

        // Spurious tx_done while idle
        pulse_done();
        repeat (3) begin
            @(negedge clk);
            check("t5_start",  32'(tx_start), 32'd0);
            check("t5_gnt",    32'(gnt),      32'd0);
            check("t5_active", 32'(active),   32'd0);
            check("t5_owner",  32'(owner),    32'd1);
        end

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog expiry with no tx_done
        do_reset();
        req = 4'b0011;
        req_data = {8'h00, 8'h00, 8'hB2, 8'hB1};
        @(negedge clk);
        check("t6_start", 32'(gnt), 32'h1);
        t0 = cyc;
        n = 0;
        while (err !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("t6_err_seen",   32'(err),      32'd1);
        check("t6_err_delay",  32'(cyc - t0), 32'(TO));
        check("t6_active_off", 32'(active),   32'd0);
        @(negedge clk);
        check("t6_next_gnt",   32'(gnt),      32'h2);
        check("t6_next_start", 32'(tx_start), 32'd1);
        req = '0;
        pulse_done();
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
